// File: rtl/hazard_pkg.sv
// Shared types and default widths for the hazard/stall controller.
package hazard_pkg;
  localparam int REG_ADDR_W_DEF   = 5;
  localparam int LOAD_LATENCY_DEF = 1;
  localparam int CNT_W_DEF        = 16;
  localparam int BUB_W            = 4;   // holds LOAD_LATENCY-1 for latencies up to 15
  localparam int ZERO_REG         = 0;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear that beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                q <= '0;
    else if (clr)              q <= '0;
    else if (inc && (q != '1)) q <= q + 1'b1;
  end
endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use stall, memory freeze and branch flush control for the 5-stage pipeline.
// Outputs are combinational from state/bubble count and current inputs.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int LOAD_LATENCY = LOAD_LATENCY_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idExMemRead,
  input  logic [REG_ADDR_W-1:0] idExRt,
  input  logic [REG_ADDR_W-1:0] ifIdRs,
  input  logic [REG_ADDR_W-1:0] ifIdRt,
  input  logic                  ifIdUsesRs,
  input  logic                  ifIdUsesRt,
  input  logic                  memBusy,
  input  logic                  branchTaken,
  input  logic                  cntClear,
  output logic                  pcWrite,
  output logic                  ifWrite,
  output logic                  idExWrite,
  output logic                  exMemWrite,
  output logic                  resetIdControl,
  output logic                  flushIfId,
  output logic [CNT_W-1:0]      stallCycles
);
  localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_LATENCY - 1);

  state_e           state, stateNxt;
  logic [BUB_W-1:0] bubbleCnt, bubbleNxt;
  logic             hazard;

  assign hazard = idExMemRead && (idExRt != REG_ADDR_W'(ZERO_REG)) &&
                  ((ifIdUsesRs && (idExRt == ifIdRs)) ||
                   (ifIdUsesRt && (idExRt == ifIdRt)));

  always_comb begin
    pcWrite        = 1'b1;
    ifWrite        = 1'b1;
    idExWrite      = 1'b1;
    exMemWrite     = 1'b1;
    resetIdControl = 1'b0;
    flushIfId      = 1'b0;
    stateNxt       = state;
    bubbleNxt      = bubbleCnt;
    if (!rst_n) begin
      pcWrite        = 1'b0;
      ifWrite        = 1'b0;
      idExWrite      = 1'b0;
      exMemWrite     = 1'b0;
      resetIdControl = 1'b1;
      flushIfId      = 1'b1;
    end else if (memBusy) begin
      // Whole pipe frozen; a pending branch re-presents once memory is ready.
      pcWrite    = 1'b0;
      ifWrite    = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
    end else if (branchTaken) begin
      // Dependent instruction is squashed, so any load wait is moot.
      flushIfId      = 1'b1;
      resetIdControl = 1'b1;
      stateNxt       = RUN;
      bubbleNxt      = '0;
    end else if (state == LOAD_WAIT) begin
      pcWrite        = 1'b0;
      ifWrite        = 1'b0;
      resetIdControl = 1'b1;
      bubbleNxt      = bubbleCnt - 1'b1;
      if (bubbleCnt == BUB_W'(1)) stateNxt = RUN;
    end else if (hazard) begin
      pcWrite        = 1'b0;
      ifWrite        = 1'b0;
      resetIdControl = 1'b1;
      if (LOAD_LATENCY > 1) begin
        stateNxt  = LOAD_WAIT;
        bubbleNxt = BUB_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      bubbleCnt <= '0;
    end else begin
      state     <= stateNxt;
      bubbleCnt <= bubbleNxt;
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pcWrite),
    .clr   (cntClear),
    .q     (stallCycles)
  );
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Vector-table bench for hazard_stall_controller across three parameter sets.
module tb_hazard_stall_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, idExMemRead, ifIdUsesRs, ifIdUsesRt, memBusy, branchTaken, cntClear;
  logic [4:0] idExRt, ifIdRs, ifIdRt;

  logic pc1, if1, id1, ex1, ri1, fl1;
  logic pc3, if3, id3, ex3, ri3, fl3;
  logic pc4, if4, id4, ex4, ri4, fl4;
  logic [15:0] cnt1, cnt3;
  logic [3:0]  cnt4;

  hazard_stall_controller u1 (
    .clk(clk), .rst_n(rst_n), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRs(ifIdUsesRs), .ifIdUsesRt(ifIdUsesRt),
    .memBusy(memBusy), .branchTaken(branchTaken), .cntClear(cntClear),
    .pcWrite(pc1), .ifWrite(if1), .idExWrite(id1), .exMemWrite(ex1),
    .resetIdControl(ri1), .flushIfId(fl1), .stallCycles(cnt1));

  hazard_stall_controller #(.LOAD_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRs(ifIdUsesRs), .ifIdUsesRt(ifIdUsesRt),
    .memBusy(memBusy), .branchTaken(branchTaken), .cntClear(cntClear),
    .pcWrite(pc3), .ifWrite(if3), .idExWrite(id3), .exMemWrite(ex3),
    .resetIdControl(ri3), .flushIfId(fl3), .stallCycles(cnt3));

  hazard_stall_controller #(.CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRs(ifIdUsesRs), .ifIdUsesRt(ifIdUsesRt),
    .memBusy(memBusy), .branchTaken(branchTaken), .cntClear(cntClear),
    .pcWrite(pc4), .ifWrite(if4), .idExWrite(id4), .exMemWrite(ex4),
    .resetIdControl(ri4), .flushIfId(fl4), .stallCycles(cnt4));

  // {pcWrite, ifWrite, idExWrite, exMemWrite, resetIdControl, flushIfId}
  localparam logic [5:0] RUNE = 6'b111100;
  localparam logic [5:0] STL  = 6'b001110;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] BRE  = 6'b111111;
  localparam logic [5:0] RSTE = 6'b000011;

  typedef struct {
    string       name;
    int          sel;
    logic        rst, rd;
    logic [4:0]  exRt, rs, rt;
    logic        uRs, uRt, busy, br, clr;
    logic [5:0]  expEn;
    logic [15:0] expCnt;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string n, int s, logic r, logic rd, int exRt, int rs, int rt,
                              logic uRs, logic uRt, logic busy, logic br, logic clr,
                              logic [5:0] en, int cnt);
    vec_t v;
    v.name = n; v.sel = s; v.rst = r; v.rd = rd;
    v.exRt = 5'(exRt); v.rs = 5'(rs); v.rt = 5'(rt);
    v.uRs = uRs; v.uRt = uRt; v.busy = busy; v.br = br; v.clr = clr;
    v.expEn = en; v.expCnt = 16'(cnt);
    return v;
  endfunction

  function automatic vec_t idle(string n, int s, logic [5:0] en, int cnt);
    return mk(n, s, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, en, cnt);
  endfunction

  function automatic vec_t rstv(int s);
    return mk("reset", s, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTE, 0);
  endfunction

  function automatic vec_t hz7(string n, int s, logic [5:0] en, int cnt);
    return mk(n, s, 1, 1, 7, 3, 7, 0, 1, 0, 0, 0, en, cnt);
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst_n = v.rst; idExMemRead = v.rd; idExRt = v.exRt; ifIdRs = v.rs; ifIdRt = v.rt;
    ifIdUsesRs = v.uRs; ifIdUsesRt = v.uRt; memBusy = v.busy; branchTaken = v.br;
    cntClear = v.clr;
    sbq.push_back(v);
  endtask

  // Monitor: outputs are combinational, so the falling edge sees the settled cycle.
  vec_t        e;
  logic [5:0]  aEn;
  logic [15:0] aCnt;
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      case (e.sel)
        1:       begin aEn = {pc1, if1, id1, ex1, ri1, fl1}; aCnt = cnt1; end
        3:       begin aEn = {pc3, if3, id3, ex3, ri3, fl3}; aCnt = cnt3; end
        default: begin aEn = {pc4, if4, id4, ex4, ri4, fl4}; aCnt = {12'b0, cnt4}; end
      endcase
      checks++;
      if (aEn !== e.expEn) begin
        errors++;
        $display("FAIL %s enables: got %b want %b", e.name, aEn, e.expEn);
      end
      checks++;
      if (aCnt !== e.expCnt) begin
        errors++;
        $display("FAIL %s stallCycles: got %0d want %0d", e.name, aCnt, e.expCnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1; idExMemRead = 0; idExRt = 0; ifIdRs = 0; ifIdRt = 0;
    ifIdUsesRs = 0; ifIdUsesRt = 0; memBusy = 0; branchTaken = 0; cntClear = 0;

    // Default parameters: single-bubble stall, exclusions, priorities, clear.
    tbl.push_back(rstv(1));
    tbl.push_back(mk("ll1_hz_rs", 1, 1, 1, 5, 5, 0, 1, 0, 0, 0, 0, STL, 0));
    tbl.push_back(idle("ll1_resume", 1, RUNE, 1));
    tbl.push_back(mk("ll1_reg0", 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, RUNE, 1));
    tbl.push_back(mk("ll1_unused_rs", 1, 1, 1, 5, 5, 0, 0, 0, 0, 0, 0, RUNE, 1));
    tbl.push_back(mk("ll1_hz_rt", 1, 1, 1, 5, 3, 5, 0, 1, 0, 0, 0, STL, 1));
    tbl.push_back(mk("ll1_nomatch", 1, 1, 1, 5, 6, 7, 1, 1, 0, 0, 0, RUNE, 2));
    tbl.push_back(mk("ll1_branch", 1, 1, 1, 5, 5, 0, 1, 0, 0, 1, 0, BRE, 2));
    tbl.push_back(mk("ll1_busy_br", 1, 1, 1, 5, 5, 0, 1, 0, 1, 1, 0, FRZ, 2));
    tbl.push_back(idle("ll1_after_busy", 1, RUNE, 3));
    tbl.push_back(mk("ll1_clr", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUNE, 3));
    tbl.push_back(idle("ll1_cleared", 1, RUNE, 0));
    tbl.push_back(mk("ll1_clr_vs_inc", 1, 1, 1, 5, 5, 0, 1, 0, 0, 0, 1, STL, 0));
    tbl.push_back(idle("ll1_clr_won", 1, RUNE, 0));

    // LOAD_LATENCY=3: three-cycle stall from one hazard.
    tbl.push_back(rstv(3));
    tbl.push_back(hz7("ll3_c0", 3, STL, 0));
    tbl.push_back(idle("ll3_c1", 3, STL, 1));
    tbl.push_back(idle("ll3_c2", 3, STL, 2));
    tbl.push_back(idle("ll3_c3", 3, RUNE, 3));
    tbl.push_back(idle("ll3_c4", 3, RUNE, 3));

    // Branch aborts the wait.
    tbl.push_back(rstv(3));
    tbl.push_back(hz7("br_c0", 3, STL, 0));
    tbl.push_back(mk("br_c1", 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, BRE, 1));
    tbl.push_back(idle("br_run", 3, RUNE, 1));
    tbl.push_back(idle("br_run2", 3, RUNE, 1));

    // memBusy freeze mid-wait with two bubbles still owed.
    tbl.push_back(rstv(3));
    tbl.push_back(hz7("mb_c0", 3, STL, 0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk("mb_frz", 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, i));
    tbl.push_back(idle("mb_wait1", 3, STL, 5));
    tbl.push_back(idle("mb_wait2", 3, STL, 6));
    tbl.push_back(idle("mb_run", 3, RUNE, 7));

    // CNT_W=4 saturation and clear.
    tbl.push_back(rstv(4));
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk("sat", 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, (i < 15) ? i : 15));
    tbl.push_back(idle("sat_hold", 4, RUNE, 15));
    tbl.push_back(mk("sat_clr", 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUNE, 15));
    tbl.push_back(idle("sat_zero", 4, RUNE, 0));

    // Asynchronous reset in the middle of a load wait.
    tbl.push_back(rstv(3));
    tbl.push_back(hz7("rw_c0", 3, STL, 0));
    tbl.push_back(idle("rw_c1", 3, STL, 1));
    tbl.push_back(rstv(3));
    tbl.push_back(idle("rw_run", 3, RUNE, 0));
    tbl.push_back(idle("rw_run2", 3, RUNE, 0));

    foreach (tbl[i]) apply(tbl[i]);

    for (int k = 0; k < 4 && sbq.size() != 0; k++) @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Parametrised successor to the single-cycle load-use stall unit in the 5-stage MIPS pipeline; sits beside the IF/ID and ID/EX registers and drives every pipeline write enable.
- Adds multi-cycle load-use bubbles (LOAD_LATENCY), exclusion of register $0 and of unused source fields, and a full-pipeline freeze while data memory is busy.
- Adds an IF/ID flush on a taken branch and a saturating stall-cycle performance counter.
- State is sequential: an FSM plus a bubble counter, so multi-cycle stalls persist after the load leaves ID/EX.

Parameters:
- REG_ADDR_W, 5, width of the register specifier fields.
- LOAD_LATENCY, 1, number of bubble cycles inserted per load-use hazard (legal range 1..15).
- CNT_W, 16, width of stallCycles.

Ports:
- clk  input  1  clock, all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- idExMemRead  input  1  instruction in ID/EX is a load.
- idExRt  input  REG_ADDR_W  load destination register.
- ifIdRs  input  REG_ADDR_W  rs of the instruction in IF/ID.
- ifIdRt  input  REG_ADDR_W  rt of the instruction in IF/ID.
- ifIdUsesRs  input  1  IF/ID instruction reads rs.
- ifIdUsesRt  input  1  IF/ID instruction reads rt.
- memBusy  input  1  data memory not ready this cycle.
- branchTaken  input  1  taken branch or jump resolved this cycle.
- cntClear  input  1  synchronous clear of stallCycles.
- pcWrite  output  1  PC load enable.
- ifWrite  output  1  IF/ID load enable.
- idExWrite  output  1  ID/EX load enable.
- exMemWrite  output  1  EX/MEM and MEM/WB load enable.
- resetIdControl  output  1  zero the control bits entering ID/EX (insert a bubble).
- flushIfId  output  1  clear IF/ID to a NOP.
- stallCycles  output  CNT_W  count of cycles with pcWrite=0, saturating.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- While rst_n=0:
  - state=RUN, bubbleCnt=0, stallCycles=0.
  - Outputs are forced to pcWrite=ifWrite=idExWrite=exMemWrite=0 and resetIdControl=flushIfId=1.
- Outputs are combinational from state, bubbleCnt and the current inputs, so they take effect in the same cycle. State updates on the clock edge.
- Hazard condition: idExMemRead && idExRt!=0 && ((ifIdUsesRs && idExRt==ifIdRs) || (ifIdUsesRt && idExRt==ifIdRt)).
- FSM has two states, RUN and LOAD_WAIT. Priority order per cycle is memBusy, then branchTaken, then the stall logic.
- memBusy=1 (highest priority), in any state:
  - pcWrite=ifWrite=idExWrite=exMemWrite=0, resetIdControl=0, flushIfId=0.
  - State and bubbleCnt hold.
  - branchTaken is ignored, because the branch is frozen and re-presents the next cycle.
- branchTaken=1 with memBusy=0:
  - flushIfId=1, resetIdControl=1, all write enables=1.
  - Next state is RUN and bubbleCnt=0; a pending load-wait is aborted because the dependent instruction is squashed.
- RUN with no hazard: all write enables=1, resetIdControl=0, flushIfId=0.
- RUN with hazard:
  - pcWrite=ifWrite=0, idExWrite=1, exMemWrite=1, resetIdControl=1.
  - If LOAD_LATENCY>1: next state LOAD_WAIT, bubbleCnt=LOAD_LATENCY-1. Otherwise stay in RUN.
- LOAD_WAIT:
  - Same stall outputs as a RUN hazard; bubbleCnt decrements each cycle.
  - When bubbleCnt==1 in this cycle, next state is RUN.
  - The hazard check is not used here; ID/EX holds a bubble.
- stallCycles:
  - Increments on every clock with pcWrite=0, including memBusy cycles, and saturates at all-ones.
  - cntClear=1 loads 0 and takes priority over increment.
- Total stall per isolated hazard is exactly LOAD_LATENCY cycles.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum with encodings RUN=1'b0, LOAD_WAIT=1'b1;
  - the constant ZERO_REG=0;
  - the default widths.
- One natural sub-module, sat_counter (parameter W; inputs inc and clr; output q), used for stallCycles. The rest is flat.

Test Plan:
- Default params; idExMemRead=1, idExRt=5, ifIdRs=5, usesRs=1 -> one cycle with pcWrite=0, resetIdControl=1; next cycle all enables=1; stallCycles=1.
- Same stimulus with idExRt=0, or with usesRs=0 -> no stall; pcWrite stays 1.
- LOAD_LATENCY=3; hazard on rt=7 in cycle 0, then idExMemRead=0 -> pcWrite=0 in cycles 0,1,2 and 1 in cycle 3; stallCycles=3.
- LOAD_LATENCY=3; branchTaken=1 in cycle 1 of the wait -> flushIfId=1, pcWrite=1 that cycle; RUN next cycle; stallCycles=1.
- memBusy=1 for 4 cycles during LOAD_WAIT with bubbleCnt=2 -> all enables 0; bubbleCnt holds at 2; resumes after release; stallCycles counts every frozen cycle.
- CNT_W=4; 20 stall cycles -> stallCycles saturates at 15; cntClear=1 -> 0 next cycle. Assert rst_n low mid-LOAD_WAIT -> immediate reset output values; RUN after release.
